pcie_prp_rx_tag_ctrl: RTL and testbench

- Write-side controller directly upstream of the PRP receive FIFO.
- Reserves FIFO space and a PCIe read tag per PRP read request, and places completion (CplD) beats at their reserved FIFO slots even when tags complete out of order.
- Publishes the in-order committed pointer so the FIFO reader only ever sees data that is contiguous and complete.
- Drives the FIFO's wr_en/wr_addr/wr_data/rear_full_addr/rear_addr/alloc_len inputs and consumes its full_n.

---
 rtl/pcie_prp_rx_tag_ctrl_if.sv | 38 +++
 rtl/pcie_prp_rx_tag_ctrl.sv | 102 ++++++++++
 tb/tb_pcie_prp_rx_tag_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_prp_rx_tag_ctrl_if.sv
// rtl/pcie_prp_rx_tag_ctrl_if.sv - request, completion and FIFO-write bundle for the PRP rx tag controller
interface pcie_prp_rx_tag_ctrl_if #(
  parameter int P_FIFO_DATA_WIDTH  = 512,
  parameter int P_FIFO_DEPTH_WIDTH = 5,
  parameter int P_TAG_WIDTH        = 2
);
  logic                          req_valid;
  logic [7:6]                    req_len;
  logic                          req_ready;
  logic [P_TAG_WIDTH-1:0]        req_tag;
  logic                          cpld_valid;
  logic [P_TAG_WIDTH-1:0]        cpld_tag;
  logic [P_FIFO_DATA_WIDTH-1:0]  cpld_data;
  logic                          fifo_wr_en;
  logic [P_FIFO_DEPTH_WIDTH-1:0] fifo_wr_addr;
  logic [P_FIFO_DATA_WIDTH-1:0]  fifo_wr_data;
  logic [P_FIFO_DEPTH_WIDTH:0]   fifo_rear_full_addr;
  logic [P_FIFO_DEPTH_WIDTH:0]   fifo_rear_addr;
  logic [7:6]                    fifo_alloc_len;
  logic                          fifo_full_n;
  logic                          tags_idle;
  logic                          err_bad_tag;
  logic                          err_overrun;

  modport slave (
    input  req_valid, req_len, cpld_valid, cpld_tag, cpld_data, fifo_full_n,
    output req_ready, req_tag, fifo_wr_en, fifo_wr_addr, fifo_wr_data,
           fifo_rear_full_addr, fifo_rear_addr, fifo_alloc_len,
           tags_idle, err_bad_tag, err_overrun
  );

  modport master (
    output req_valid, req_len, cpld_valid, cpld_tag, cpld_data, fifo_full_n,
    input  req_ready, req_tag, fifo_wr_en, fifo_wr_addr, fifo_wr_data,
           fifo_rear_full_addr, fifo_rear_addr, fifo_alloc_len,
           tags_idle, err_bad_tag, err_overrun
  );
endinterface

// File: rtl/pcie_prp_rx_tag_ctrl.sv
// rtl/pcie_prp_rx_tag_ctrl.sv - reserves FIFO space per read tag, places CplD beats, commits in order
module pcie_prp_rx_tag_ctrl #(
  parameter int P_FIFO_DATA_WIDTH  = 512,
  parameter int P_FIFO_DEPTH_WIDTH = 5,
  parameter int P_TAG_WIDTH        = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pcie_prp_rx_tag_ctrl_if.slave bus
);
  localparam int D  = P_FIFO_DEPTH_WIDTH;
  localparam int NT = 1 << P_TAG_WIDTH;

  logic [NT-1:0]                valid_q, done_q;
  logic [D:0]                   base_q [NT];
  logic [1:0]                   len_q  [NT];
  logic [1:0]                   cnt_q  [NT];
  logic [P_TAG_WIDTH-1:0]       alloc_tag_q, retire_tag_q;
  logic [D:0]                   rear_full_q, rear_q;
  logic                         wr_en_q;
  logic [D-1:0]                 wr_addr_q;
  logic [P_FIFO_DATA_WIDTH-1:0] wr_data_q;
  logic                         err_bad_q, err_ovr_q;

  logic [1:0]             req_len_eff;
  logic                   accept, retire;
  logic                   cpld_hit, cpld_bad, cpld_ovr;
  logic [P_TAG_WIDTH-1:0] ct;
  logic [D:0]             cpld_ptr;

  // A zero length is a protocol violation; reserve one beat so pointers stay sane.
  assign req_len_eff = (bus.req_len == 2'd0) ? 2'd1 : bus.req_len;
  assign ct          = bus.cpld_tag;
  assign accept      = bus.req_valid & bus.fifo_full_n & ~valid_q[alloc_tag_q];
  assign retire      = valid_q[retire_tag_q] & done_q[retire_tag_q];
  assign cpld_bad    = bus.cpld_valid & ~valid_q[ct];
  assign cpld_ovr    = bus.cpld_valid & valid_q[ct] & done_q[ct];
  assign cpld_hit    = bus.cpld_valid & valid_q[ct] & ~done_q[ct];
  assign cpld_ptr    = base_q[ct] + {{(D-1){1'b0}}, cnt_q[ct]};

  // Accept needs an invalid entry, retire and completion writes need valid ones, and a
  // completion write never touches a done entry, so the three updates hit disjoint tags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NT; i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
        cnt_q[i]  <= '0;
      end
      valid_q      <= '0;
      done_q       <= '0;
      alloc_tag_q  <= '0;
      retire_tag_q <= '0;
      rear_full_q  <= '0;
      rear_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      err_bad_q    <= 1'b0;
      err_ovr_q    <= 1'b0;
    end else begin
      wr_en_q <= cpld_hit;
      if (cpld_hit) begin
        wr_addr_q  <= cpld_ptr[D-1:0];
        wr_data_q  <= bus.cpld_data;
        cnt_q[ct]  <= cnt_q[ct] + 2'd1;
        if ((cnt_q[ct] + 2'd1) == len_q[ct]) done_q[ct] <= 1'b1;
      end
      if (cpld_bad) err_bad_q <= 1'b1;
      if (cpld_ovr) err_ovr_q <= 1'b1;

      if (accept) begin
        valid_q[alloc_tag_q] <= 1'b1;
        done_q[alloc_tag_q]  <= 1'b0;
        base_q[alloc_tag_q]  <= rear_full_q;
        len_q[alloc_tag_q]   <= req_len_eff;
        cnt_q[alloc_tag_q]   <= 2'd0;
        rear_full_q          <= rear_full_q + {{(D-1){1'b0}}, req_len_eff};
        alloc_tag_q          <= alloc_tag_q + 1'b1;
      end

      if (retire) begin
        rear_q                <= rear_q + {{(D-1){1'b0}}, len_q[retire_tag_q]};
        valid_q[retire_tag_q] <= 1'b0;
        done_q[retire_tag_q]  <= 1'b0;
        cnt_q[retire_tag_q]   <= 2'd0;
        retire_tag_q          <= retire_tag_q + 1'b1;
      end
    end
  end

  assign bus.req_ready           = accept;
  assign bus.req_tag             = alloc_tag_q;
  assign bus.fifo_alloc_len      = bus.req_len;
  assign bus.fifo_wr_en          = wr_en_q;
  assign bus.fifo_wr_addr        = wr_addr_q;
  assign bus.fifo_wr_data        = wr_data_q;
  assign bus.fifo_rear_full_addr = rear_full_q;
  assign bus.fifo_rear_addr      = rear_q;
  assign bus.tags_idle           = ~|valid_q;
  assign bus.err_bad_tag         = err_bad_q;
  assign bus.err_overrun         = err_ovr_q;
endmodule

// File: tb/tb_pcie_prp_rx_tag_ctrl.sv
// tb/tb_pcie_prp_rx_tag_ctrl.sv - scoreboard bench for pcie_prp_rx_tag_ctrl
module tb_pcie_prp_rx_tag_ctrl;
  typedef struct {
    logic [4:0]   addr;
    logic [511:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  pcie_prp_rx_tag_ctrl_if #(.P_FIFO_DATA_WIDTH(512), .P_FIFO_DEPTH_WIDTH(5), .P_TAG_WIDTH(2)) bus ();

  pcie_prp_rx_tag_ctrl #(.P_FIFO_DATA_WIDTH(512), .P_FIFO_DEPTH_WIDTH(5), .P_TAG_WIDTH(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: per-tag reservation records plus the request order.
  wr_t        wq[$];
  logic [5:0] rq[$];
  int         ord[$];
  logic [5:0] m_base [4];
  int         m_len  [4];
  int         m_got  [4];
  logic [5:0] m_rear_full;
  logic [5:0] m_rear;
  int         m_alloc;
  logic [5:0] last_rear;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requests commit in issue order once every earlier request has all its beats.
  task automatic commit_model();
    while (ord.size() > 0 && m_got[ord[0]] == m_len[ord[0]]) begin
      m_rear = m_rear + 6'(m_len[ord[0]]);
      rq.push_back(m_rear);
      void'(ord.pop_front());
    end
  endtask

  task automatic model_reset();
    wq.delete(); rq.delete(); ord.delete();
    for (int i = 0; i < 4; i++) begin
      m_base[i] = '0; m_len[i] = 0; m_got[i] = 0;
    end
    m_rear_full = '0; m_rear = '0; m_alloc = 0;
  endtask

  task automatic model_alloc(input int len);
    int eff;
    eff = (len == 0) ? 1 : len;
    m_base[m_alloc] = m_rear_full;
    m_len[m_alloc]  = eff;
    m_got[m_alloc]  = 0;
    ord.push_back(m_alloc);
    m_rear_full = m_rear_full + 6'(eff);
    m_alloc = (m_alloc + 1) % 4;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_rear = '0;
    end else begin
      if (bus.fifo_wr_en) begin
        if (wq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write: got addr %0d, none expected", bus.fifo_wr_addr);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", 512'(bus.fifo_wr_addr), 512'(e.addr));
          chk("wr_data", bus.fifo_wr_data, e.data);
        end
      end
      if (bus.fifo_rear_addr !== last_rear) begin
        if (rq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_rear_addr: got %0d, no advance expected", bus.fifo_rear_addr);
        end else begin
          chk("rear_addr", 512'(bus.fifo_rear_addr), 512'(rq.pop_front()));
        end
        last_rear = bus.fifo_rear_addr;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; bus.req_valid = 1'b0; bus.cpld_valid = 1'b0; bus.fifo_full_n = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_req(input int len);
    bit ok;
    @(posedge clk); #1;
    bus.cpld_valid = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_len    = 2'(len);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL req_timeout: req_ready stayed %0b, required 1", bus.req_ready);
    end else begin
      chk("req_tag", 512'(bus.req_tag), 512'(m_alloc));
      chk("alloc_len", 512'(bus.fifo_alloc_len), 512'(len));
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (ok) begin
      model_alloc(len);
      chk("rear_full_addr", 512'(bus.fifo_rear_full_addr), 512'(m_rear_full));
    end
  endtask

  task automatic drive_beat(input int t, output logic [511:0] d);
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    @(posedge clk); #1;
    bus.cpld_valid = 1'b1;
    bus.cpld_tag   = 2'(t);
    bus.cpld_data  = d;
  endtask

  task automatic beat(input int t);
    logic [511:0] d;
    logic [5:0]   p;
    wr_t          e;
    drive_beat(t, d);
    p = m_base[t] + 6'(m_got[t]);
    e.addr = p[4:0];
    e.data = d;
    wq.push_back(e);
    m_got[t]++;
    commit_model();
  endtask

  task automatic raw_beat(input int t);
    logic [511:0] d;
    drive_beat(t, d);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.cpld_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.tags_idle && wq.size() == 0 && rq.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: tags_idle=%0b writes_left=%0d commits_left=%0d",
               bus.tags_idle, wq.size(), rq.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pend[$];
    bus.req_valid = 1'b0; bus.req_len = 2'd1; bus.cpld_valid = 1'b0;
    bus.cpld_tag = '0; bus.cpld_data = '0; bus.fifo_full_n = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_tags_idle", 512'(bus.tags_idle), 512'(1));
    chk("reset_rear_full", 512'(bus.fifo_rear_full_addr), 512'(0));
    chk("reset_rear", 512'(bus.fifo_rear_addr), 512'(0));
    chk("reset_wr_en", 512'(bus.fifo_wr_en), 512'(0));
    chk("reset_err_bad", 512'(bus.err_bad_tag), 512'(0));
    chk("reset_err_ovr", 512'(bus.err_overrun), 512'(0));

    // Basic: len2 on tag0, commit two cycles after the last beat.
    do_req(2);
    beat(0); beat(0); idle();
    @(negedge clk);
    chk("basic_rear_hold", 512'(bus.fifo_rear_addr), 512'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("basic_rear_commit", 512'(bus.fifo_rear_addr), 512'(2));
    chk("basic_tags_idle", 512'(bus.tags_idle), 512'(1));

    // Out of order: tag1 (len3) completes before tag0 (len1).
    do_reset();
    do_req(1); do_req(3);
    beat(1); beat(1); beat(1); idle();
    repeat (3) @(negedge clk);
    chk("ooo_rear_hold", 512'(bus.fifo_rear_addr), 512'(0));
    beat(0); idle();
    wait_idle();
    chk("ooo_rear_final", 512'(bus.fifo_rear_addr), 512'(4));

    // Backpressure: nothing accepted, no tag consumed.
    do_reset();
    @(posedge clk); #1;
    bus.fifo_full_n = 1'b0; bus.req_valid = 1'b1; bus.req_len = 2'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_req_ready", 512'(bus.req_ready), 512'(0));
      chk("bp_rear_full", 512'(bus.fifo_rear_full_addr), 512'(m_rear_full));
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.fifo_full_n = 1'b1;
    do_req(1);
    beat(0); idle(); wait_idle();

    // Tag exhaustion: fifth request waits for tag0 to retire.
    do_reset();
    for (int i = 0; i < 4; i++) do_req(1);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_len = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("exh_held", 512'(bus.req_ready), 512'(0));
    end
    beat(0);
    @(negedge clk);
    chk("exh_held_beat", 512'(bus.req_ready), 512'(0));
    idle();
    @(negedge clk);
    chk("exh_held_done", 512'(bus.req_ready), 512'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("exh_accept", 512'(bus.req_ready), 512'(1));
    chk("exh_tag", 512'(bus.req_tag), 512'(0));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    model_alloc(1);
    beat(2); beat(1); beat(0); beat(3); idle();
    wait_idle();

    // Random traffic: random lengths (including the illegal 0), random beat order.
    do_reset();
    for (int r = 0; r < 30; r++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) do_req($urandom_range(0, 3));
      forever begin
        pend.delete();
        for (int t = 0; t < 4; t++)
          foreach (ord[k]) if (ord[k] == t && m_got[t] < m_len[t]) pend.push_back(t);
        if (pend.size() == 0) break;
        beat(pend[$urandom_range(0, pend.size() - 1)]);
        if ($urandom_range(0, 2) == 0) idle();
      end
      idle();
      wait_idle();
    end

    // Wrap: bring both pointers to 31, then reserve three beats across the end.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      do_req(3); beat(0 + (i % 4)); beat(i % 4); beat(i % 4); idle(); wait_idle();
    end
    do_req(1); beat(2); idle(); wait_idle();
    chk("wrap_start_rear", 512'(bus.fifo_rear_addr), 512'(31));
    do_req(3);
    chk("wrap_rear_full", 512'(bus.fifo_rear_full_addr), 512'(34));
    beat(3); beat(3); beat(3); idle(); wait_idle();
    chk("wrap_rear", 512'(bus.fifo_rear_addr), 512'(34));

    // Errors: beat on free tag, then a fourth beat on a len3 tag.
    raw_beat(2); idle();
    @(negedge clk);
    chk("bad_tag_flag", 512'(bus.err_bad_tag), 512'(1));
    chk("bad_tag_no_ovr", 512'(bus.err_overrun), 512'(0));
    do_req(3);
    beat(0); beat(0); beat(0); raw_beat(0); idle();
    @(negedge clk);
    chk("overrun_flag", 512'(bus.err_overrun), 512'(1));
    wait_idle();

    do_reset();
    @(negedge clk);
    chk("rst_err_bad", 512'(bus.err_bad_tag), 512'(0));
    chk("rst_err_ovr", 512'(bus.err_overrun), 512'(0));
    chk("rst_rear_full", 512'(bus.fifo_rear_full_addr), 512'(0));
    chk("rst_rear", 512'(bus.fifo_rear_addr), 512'(0));
    chk("rst_tags_idle", 512'(bus.tags_idle), 512'(1));

    chk("pending_writes", 512'(wq.size()), 512'(0));
    chk("pending_commits", 512'(rq.size()), 512'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
